rr_sel_arbiter: RTL and testbench

RR_SEL_ARBITER -- requirements
Module: rr_sel_arbiter

---
 rtl/mux_pkg.sv | 19 +
 rtl/rr_pick.sv | 43 ++++
 rtl/rr_sel_arbiter.sv | 126 ++++++++++++
 tb/tb_rr_sel_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared types for the select-arbiter / muxpipe family.
//  Revision    : 1.0
// ============================================================================
package mux_pkg;

    // Arbiter ownership state: IDLE = no owner, LOCKED = one source owns the mux.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    localparam int MIN_INPUTS = 2;
    localparam int MAX_INPUTS = 64;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Stateless rotating-priority pick: first set bit at or after
//                ptr+1 (wrapping), as one-hot and binary index.
//  Revision    : 1.0
// ============================================================================
module rr_pick #(
    parameter int INPUTS = 4
) (
    input  logic [INPUTS-1:0]         req_i,
    input  logic [$clog2(INPUTS)-1:0] ptr_i,
    output logic                      valid_o,
    output logic [INPUTS-1:0]         onehot_o,
    output logic [$clog2(INPUTS)-1:0] idx_o
);

    localparam int W = $clog2(INPUTS);

    // Scan from the farthest candidate down to ptr+1 so the nearest hit wins.
    always_comb begin
        valid_o  = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        for (int k = INPUTS; k >= 1; k--) begin
            logic [W:0]   cand_ext;
            logic [W-1:0] cand;
            cand_ext = {1'b0, ptr_i} + (W+1)'(k);
            if (cand_ext >= (W+1)'(INPUTS)) begin
                cand_ext = cand_ext - (W+1)'(INPUTS);
            end
            cand = cand_ext[W-1:0];
            if (req_i[cand]) begin
                valid_o        = 1'b1;
                onehot_o       = '0;
                onehot_o[cand] = 1'b1;
                idx_o          = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_sel_arbiter
//  Description : Packet-locking round-robin arbiter driving a muxpipe select,
//                with a PIPELINE-deep accepted-beat valid delay.
//  Revision    : 1.0
// ============================================================================
module rr_sel_arbiter #(
    parameter int INPUTS   = 4,
    parameter int PIPELINE = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [INPUTS-1:0]         req,
    input  logic [INPUTS-1:0]         last,
    input  logic                      o_ready,
    output logic [INPUTS-1:0]         ack,
    output logic [INPUTS-1:0]         grant,
    output logic [$clog2(INPUTS)-1:0] sel,
    output logic                      o_valid,
    output logic                      o_valid_q
);

    import mux_pkg::*;

    localparam int SW = $clog2(INPUTS);

    arb_state_e        state_q, state_d;
    logic [INPUTS-1:0] grant_q, grant_d;
    logic [SW-1:0]     sel_q,   sel_d;
    logic [SW-1:0]     ptr_q,   ptr_d;

    logic [INPUTS-1:0] pick_req;
    logic [SW-1:0]     pick_ptr;
    logic              pick_valid;
    logic [INPUTS-1:0] pick_onehot;
    logic [SW-1:0]     pick_idx;
    logic              owner_done;
    logic              accept;

    assign ack        = grant_q & req & {INPUTS{o_ready}};
    assign o_valid    = |(grant_q & req);
    assign accept     = o_valid & o_ready;
    assign grant      = grant_q;
    assign sel        = sel_q;
    assign owner_done = (state_q == ST_LOCKED) && |(ack & last);

    // On release the finishing owner becomes the pointer and is masked out,
    // so it ranks last and cannot re-win on the same edge.
    assign pick_req = (state_q == ST_LOCKED) ? (req & ~grant_q) : req;
    assign pick_ptr = (state_q == ST_LOCKED) ? sel_q : ptr_q;

    rr_pick #(
        .INPUTS   (INPUTS)
    ) u_pick (
        .req_i    (pick_req),
        .ptr_i    (pick_ptr),
        .valid_o  (pick_valid),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= SW'(INPUTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_LOCKED;
                    grant_d = pick_onehot;
                    sel_d   = pick_idx;
                end
            end
            ST_LOCKED: begin
                if (owner_done) begin
                    ptr_d = sel_q;
                    if (pick_valid) begin
                        grant_d = pick_onehot;
                        sel_d   = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    generate
        if (PIPELINE == 0) begin : g_valid_comb
            assign o_valid_q = accept;
        end else begin : g_valid_pipe
            logic [PIPELINE-1:0] vpipe_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vpipe_q <= '0;
                end else begin
                    vpipe_q <= (vpipe_q << 1) | PIPELINE'(accept);
                end
            end
            assign o_valid_q = vpipe_q[PIPELINE-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rr_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_sel_arbiter
//  Description : Directed bench for rr_sel_arbiter (INPUTS=4, PIPELINE 0 and 2)
//                with a packet-level reference model.
//  Revision    : 1.0
// ============================================================================
module tb_rr_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, last;
    logic       o_ready;

    logic [3:0] ack1, grant1, ack2, grant2;
    logic [1:0] sel1, sel2;
    logic       o_valid1, o_valid_q1, o_valid2, o_valid_q2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rr_sel_arbiter #(.INPUTS(4), .PIPELINE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last), .o_ready(o_ready),
        .ack(ack1), .grant(grant1), .sel(sel1), .o_valid(o_valid1), .o_valid_q(o_valid_q1)
    );

    rr_sel_arbiter #(.INPUTS(4), .PIPELINE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last), .o_ready(o_ready),
        .ack(ack2), .grant(grant2), .sel(sel2), .o_valid(o_valid2), .o_valid_q(o_valid_q2)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 when idle), round-robin pointer, held select.
    int         m_owner;
    int         m_ptr;
    int         m_sel;
    logic       p1, p2;
    logic [3:0] eg, ea;
    logic       ev;
    int         nxt;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (p + k) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_grant", grant1, 0);
            check("rst_sel", sel1, 0);
            check("rst_ack", ack1, 0);
            check("rst_vq0", o_valid_q1, 0);
            check("rst_grant_p2", grant2, 0);
            check("rst_vq2", o_valid_q2, 0);
            m_owner = -1; m_ptr = 3; m_sel = 0; p1 = 1'b0; p2 = 1'b0;
        end else begin
            eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            ev = |(eg & req);
            ea = ev && o_ready ? eg : 4'b0000;
            check("model_grant", grant1, eg);
            check("model_sel", sel1, m_sel);
            check("model_ack", ack1, ea);
            check("model_valid", o_valid1, ev);
            check("model_vq0", o_valid_q1, ev & o_ready);
            check("model_grant_p2", grant2, eg);
            check("model_ack_p2", ack2, ea);
            check("model_vq2", o_valid_q2, p2);
            p2 = p1;
            p1 = ev & o_ready;
            if (m_owner < 0) begin
                nxt = pick(req, m_ptr);
                if (nxt >= 0) begin m_owner = nxt; m_sel = nxt; end
            end else if (ea != 0 && last[m_owner]) begin
                m_ptr   = m_owner;
                nxt     = pick(req & ~eg, m_ptr);
                m_owner = nxt;
                if (nxt >= 0) m_sel = nxt;
            end
        end
    end

    task automatic step(input logic r_n, input logic [3:0] r, input logic [3:0] l, input logic rdy);
        @(posedge clk);
        #1;
        rst_n = r_n; req = r; last = l; o_ready = rdy;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = '0; last = '0; o_ready = 1'b0;
        step(0, 4'b0000, 4'b0000, 0);
        step(0, 4'b0000, 4'b0000, 0);
        check("reset_grant", grant1, 0);
        check("reset_sel", sel1, 0);
        check("reset_vq2", o_valid_q2, 0);

        // All sources request single-beat packets: grants rotate 0,1,2,3,0.
        step(1, 4'b1111, 4'b1111, 1); check("a0_grant", grant1, 4'b0000);
        step(1, 4'b1111, 4'b1111, 1); check("a1_grant", grant1, 4'b0001); check("a1_ack", ack1, 4'b0001);
        step(1, 4'b1111, 4'b1111, 1); check("a2_grant", grant1, 4'b0010); check("a2_ack", ack1, 4'b0010);
        step(1, 4'b1111, 4'b1111, 1); check("a3_grant", grant1, 4'b0100); check("a3_sel", sel1, 2);
        step(1, 4'b1111, 4'b1111, 1); check("a4_grant", grant1, 4'b1000); check("a4_sel", sel1, 3);
        step(1, 4'b0001, 4'b1111, 1); check("a5_grant", grant1, 4'b0001); check("a5_ack", ack1, 4'b0001);
        step(1, 4'b0000, 4'b0000, 1); check("a6_idle", grant1, 4'b0000); check("a6_sel", sel1, 0);

        // Three-beat packet on source 2 with a downstream stall on beat 2.
        step(1, 4'b0100, 4'b0000, 1); check("b0_grant", grant1, 4'b0000);
        step(1, 4'b0100, 4'b0000, 1); check("b1_ack", ack1, 4'b0100); check("b1_sel", sel1, 2);
        step(1, 4'b0100, 4'b0000, 0); check("b2_stall_ack", ack1, 4'b0000); check("b2_grant", grant1, 4'b0100);
        step(1, 4'b0100, 4'b0000, 1); check("b3_ack", ack1, 4'b0100);
        step(1, 4'b0100, 4'b0100, 1); check("b4_ack", ack1, 4'b0100);
        step(1, 4'b0000, 4'b0000, 1); check("b5_release", grant1, 4'b0000); check("b5_sel_held", sel1, 2);

        // Owner 1 drops req mid-packet while source 0 waits.
        step(1, 4'b0010, 4'b0000, 1); check("c0_grant", grant1, 4'b0000);
        step(1, 4'b0011, 4'b0000, 1); check("c1_ack", ack1, 4'b0010);
        step(1, 4'b0001, 4'b0000, 1); check("c2_grant", grant1, 4'b0010); check("c2_ack", ack1, 4'b0000);
        step(1, 4'b0001, 4'b0000, 1); check("c3_grant", grant1, 4'b0010); check("c3_ack", ack1, 4'b0000);
        step(1, 4'b0011, 4'b0010, 1); check("c4_ack", ack1, 4'b0010);
        step(1, 4'b0001, 4'b0001, 1); check("c5_nobubble", grant1, 4'b0001); check("c5_ack", ack1, 4'b0001);
        step(1, 4'b0000, 4'b0000, 1); check("c6_idle", grant1, 4'b0000);

        // Reset mid-packet of source 3; afterwards source 0 wins over 3.
        step(1, 4'b1000, 4'b0000, 1);
        step(1, 4'b1000, 4'b0000, 1); check("d1_grant", grant1, 4'b1000);
        step(1, 4'b1001, 4'b0000, 1); check("d2_ack", ack1, 4'b1000);
        step(0, 4'b1001, 4'b0000, 1); check("d3_rst_grant", grant1, 4'b0000); check("d3_rst_sel", sel1, 0);
        check("d3_rst_ack", ack1, 4'b0000);
        step(0, 4'b1001, 4'b1001, 1);
        step(1, 4'b1001, 4'b1001, 1); check("d5_grant", grant1, 4'b0000);
        step(1, 4'b1001, 4'b1001, 1); check("d6_src0_first", grant1, 4'b0001);
        step(1, 4'b1000, 4'b1000, 1); check("d7_grant", grant1, 4'b1000);
        step(1, 4'b0000, 4'b0000, 1); check("d8_sel_held", sel1, 3);
        step(1, 4'b0000, 4'b0000, 1);
        step(1, 4'b0000, 4'b0000, 1);

        // Single beat through the PIPELINE=2 instance.
        step(1, 4'b0010, 4'b0010, 1); check("e0_vq2", o_valid_q2, 0);
        step(1, 4'b0010, 4'b0010, 1); check("e1_ack_p2", ack2, 4'b0010); check("e1_vq0", o_valid_q1, 1);
        check("e1_vq2", o_valid_q2, 0);
        step(1, 4'b0000, 4'b0000, 1); check("e2_vq2", o_valid_q2, 0);
        step(1, 4'b0000, 4'b0000, 1); check("e3_vq2", o_valid_q2, 1);
        step(1, 4'b0000, 4'b0000, 1); check("e4_vq2", o_valid_q2, 0);

        // Lone requester: one idle bubble between single-beat packets.
        step(1, 4'b0010, 4'b0010, 1); check("f0_grant", grant1, 4'b0000);
        step(1, 4'b0010, 4'b0010, 1); check("f1_grant", grant1, 4'b0010);
        step(1, 4'b0010, 4'b0010, 1); check("f2_bubble", grant1, 4'b0000);
        step(1, 4'b0010, 4'b0010, 1); check("f3_grant", grant1, 4'b0010);
        step(1, 4'b0010, 4'b0010, 1); check("f4_bubble", grant1, 4'b0000);
        step(1, 4'b0010, 4'b0010, 1); check("f5_grant", grant1, 4'b0010);
        step(1, 4'b0000, 4'b0000, 1); check("f6_idle", grant1, 4'b0000);
        step(1, 4'b0000, 4'b0000, 1);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
